// File: rtl/l2_data_array_ctrl.sv
// l2_data_array_ctrl: front end for one L2 data-array SRAM port.
// One request per cycle goes straight through to the array. Reads return
// through a small in-order response FIFO. A credit check makes sure every
// accepted read already has a FIFO slot waiting for it.
`timescale 1ns/1ps

module l2_data_array_ctrl #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 1024,
  parameter int MASK_W     = 16,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,

  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,

  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  // A pointer needs at least one bit, even when the FIFO has one entry.
  // The count must be able to hold the value RESP_DEPTH.
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(RESP_DEPTH);

  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              inflight;

  logic [CNT_W:0]    pending;
  logic              credit_ok;
  logic              fire;
  logic              read_fire;
  logic              push;
  logic              pop;

  // Pointer increment that wraps at RESP_DEPTH. The depth does not need
  // to be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake and credit logic. Only registered state feeds the credit
  // check, so a slot freed by a pop this cycle is not used until next cycle.
  always_comb begin
    pending   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    credit_ok = (pending < DEPTH_LIM);
    req_ready = reset_n & (req_write | credit_ok);
    fire      = req_valid & req_ready;
    read_fire = fire & ~req_write;
    push      = inflight;
    pop       = (fifo_count != '0) & resp_ready;
  end

  // Array port pass-through. Every field is forced to zero when the port is idle.
  always_comb begin
    sram_en    = fire;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (fire) begin
      sram_wmode = req_write;
      sram_addr  = req_addr;
      sram_wmask = req_wmask;
      sram_wdata = req_wdata;
    end
  end

  // Response side. The FIFO head is presented directly, so it holds steady until it is popped.
  always_comb begin
    resp_valid = (fifo_count != '0);
    resp_rdata = fifo_mem[rd_ptr];
  end

  // Track the single read whose array data arrives next cycle. Reset drops it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= read_fire;
    end
  end

  // Capture array read data one cycle after the read fires.
  always_ff @(posedge clock) begin
    if (push && reset_n) begin
      fifo_mem[wr_ptr] <= sram_rdata;
    end
  end

  // FIFO pointers. Push and pop may happen in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end

  // Occupancy count. A push and a pop in the same cycle cancel out.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fifo_count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_data_array_ctrl.sv
// tb_l2_data_array_ctrl: directed bench for l2_data_array_ctrl with a
// behavioural SRAM model behind the array port.
`timescale 1ns/1ps

module tb_l2_data_array_ctrl;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 1024;
  localparam int MASK_W     = 16;
  localparam int RESP_DEPTH = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] pat_a, pat_b, pat_c, pat_d;
  logic [DATA_W-1:0] p1, p2, p3, p4;
  logic [DATA_W-1:0] exp_q [$];

  always #5 clock = ~clock;

  l2_data_array_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural array. Read data is valid only in the cycle after a read
  // enable. At all other times the model drives all-ones, so a capture at
  // the wrong cycle shows up as wrong data.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  always @(posedge clock) begin
    logic [DATA_W-1:0] row;
    if (sram_en) begin
      row = mem.exists(sram_addr) ? mem[sram_addr] : '0;
      if (sram_wmode) begin
        for (int l = 0; l < MASK_W; l++)
          if (sram_wmask[l]) row[l*64 +: 64] = sram_wdata[l*64 +: 64];
        mem[sram_addr] = row;
        sram_rdata <= '1;
      end else begin
        sram_rdata <= row;
      end
    end else begin
      sram_rdata <= '1;
    end
  end

  // Build a row pattern. Each 64-bit lane carries the tag and its own lane index.
  function automatic logic [DATA_W-1:0] pat(input logic [15:0] tag);
    logic [DATA_W-1:0] p;
    for (int l = 0; l < MASK_W; l++) p[l*64 +: 64] = {tag, 40'h0, 8'(l)};
    return p;
  endfunction

  // Drive one cycle of inputs at the falling edge, then settle briefly before any check.
  task automatic applyStimulus(input logic rst_n, input logic v, input logic w,
                               input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m,
                               input logic [DATA_W-1:0] d, input logic rr);
    @(negedge clock);
    reset_n    = rst_n;
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wmask  = m;
    req_wdata  = d;
    resp_ready = rr;
    #1;
  endtask

  // Compare one observed value against its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("[TB] FAIL %s: got hi=%h lo=%h required hi=%h lo=%h", tag,
             got[DATA_W-1 -: 64], got[63:0], expv[DATA_W-1 -: 64], expv[63:0]);
    end
  endtask

  // Watchdog: stops the run if the directed sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tb_count;
    int tb_inflight;
    int idx;
    int cyc;
    logic exp_ready;
    logic fire_m;
    logic popped;
    logic [ADDR_W-1:0] rows [6];

    pat_a = pat(16'hAAAA);
    pat_b = pat(16'hBBBB);
    pat_d = pat(16'hDDDD);
    p1 = pat(16'h0001);
    p2 = pat(16'h0002);
    p3 = pat(16'h0003);
    p4 = pat(16'h0004);
    pat_c = pat_a;
    pat_c[63:0] = pat_b[63:0];

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wmask = '0; req_wdata = '0; resp_ready = 1'b0;

    // Reset: a read is offered but the block must not accept it.
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h0005, '0, '0, 1'b1);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_sram_en", sram_en, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h0005, '0, '0, 1'b1);
    checkOutput("rst_resp_valid", resp_valid, 0);

    // First cycle after release: ready at once, idle port driven to zero.
    applyStimulus(1'b1, 1'b0, 1'b1, 14'h1234, 16'hFFFF, pat_b, 1'b1);
    checkOutput("rel_req_ready", req_ready, 1);
    checkOutput("idle_sram_en", sram_en, 0);
    checkOutput("idle_sram_wmode", sram_wmode, 0);
    checkOutput("idle_sram_addr", sram_addr, 0);
    checkOutput("idle_sram_wmask", sram_wmask, 0);
    checkOutput("idle_sram_wdata", sram_wdata, 0);

    // Full write of pattern A to row 5.
    applyStimulus(1'b1, 1'b1, 1'b1, 14'h0005, 16'hFFFF, pat_a, 1'b1);
    checkOutput("wr_sram_en", sram_en, 1);
    checkOutput("wr_sram_wmode", sram_wmode, 1);
    checkOutput("wr_sram_addr", sram_addr, 14'h0005);
    checkOutput("wr_sram_wmask", sram_wmask, 16'hFFFF);
    checkOutput("wr_sram_wdata", sram_wdata, pat_a);

    // Read row 5: two-cycle latency.
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0005, '0, '0, 1'b1);
    checkOutput("rd_sram_en", sram_en, 1);
    checkOutput("rd_sram_wmode", sram_wmode, 0);
    checkOutput("rd_resp_valid_n", resp_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("rd_resp_valid_n1", resp_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("rd_resp_valid_n2", resp_valid, 1);
    checkOutput("rd_rdata_a", resp_rdata, pat_a);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("rd_resp_popped", resp_valid, 0);

    // Lane-0-only write of B, then read back the merged row.
    applyStimulus(1'b1, 1'b1, 1'b1, 14'h0005, 16'h0001, pat_b, 1'b1);
    checkOutput("mwr_sram_wmask", sram_wmask, 16'h0001);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0005, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("mrd_resp_valid", resp_valid, 1);
    checkOutput("mrd_rdata_merged", resp_rdata, pat_c);

    // A write with an empty mask still issues, and no response follows it.
    applyStimulus(1'b1, 1'b1, 1'b1, 14'h0007, 16'h0000, pat_d, 1'b1);
    checkOutput("w0_sram_en", sram_en, 1);
    checkOutput("w0_sram_wmode", sram_wmode, 1);
    checkOutput("w0_sram_wmask", sram_wmask, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("w0_no_resp", resp_valid, 0);

    // Preload rows 1..3 and the top row.
    applyStimulus(1'b1, 1'b1, 1'b1, 14'h0001, 16'hFFFF, p1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 14'h0002, 16'hFFFF, p2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 14'h0003, 16'hFFFF, p3, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 14'h3FFF, 16'hFFFF, pat_d, 1'b1);

    // Read of the maximum address.
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h3FFF, '0, '0, 1'b1);
    checkOutput("max_sram_addr", sram_addr, 14'h3FFF);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("max_rdata", resp_rdata, pat_d);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);

    // Backpressure: two reads fill the credits and the third waits.
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0001, '0, '0, 1'b0);
    checkOutput("bp_c0_ready", req_ready, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0002, '0, '0, 1'b0);
    checkOutput("bp_c1_ready", req_ready, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0003, '0, '0, 1'b0);
    checkOutput("bp_c2_ready", req_ready, 0);
    checkOutput("bp_c2_sram_en", sram_en, 0);
    checkOutput("bp_c2_rdata", resp_rdata, p1);
    applyStimulus(1'b1, 1'b1, 1'b1, 14'h0004, 16'hFFFF, p4, 1'b0);
    checkOutput("bp_wr_ready", req_ready, 1);
    checkOutput("bp_wr_sram_en", sram_en, 1);
    checkOutput("bp_c3_rdata_stable", resp_rdata, p1);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0003, '0, '0, 1'b1);
    checkOutput("bp_pop_no_credit", req_ready, 0);
    checkOutput("bp_c4_rdata", resp_rdata, p1);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0003, '0, '0, 1'b0);
    checkOutput("bp_c5_ready", req_ready, 1);
    checkOutput("bp_c5_sram_addr", sram_addr, 14'h0003);
    checkOutput("bp_c5_rdata", resp_rdata, p2);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("bp_c6_rdata", resp_rdata, p2);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("bp_c7_rdata", resp_rdata, p3);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("bp_c8_empty", resp_valid, 0);

    // Full FIFO drained while continuous reads are offered. The model
    // tracks FIFO occupancy plus the one read whose data is still coming.
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0001, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0002, '0, '0, 1'b0);
    exp_q.push_back(p1);
    exp_q.push_back(p2);
    tb_count = 1;
    tb_inflight = 1;
    rows[0] = 14'h0003; rows[1] = 14'h0004; rows[2] = 14'h0001;
    rows[3] = 14'h0002; rows[4] = 14'h0003; rows[5] = 14'h0004;
    idx = 0;
    cyc = 0;
    while ((idx < 6 || exp_q.size() > 0) && cyc < 40) begin
      applyStimulus(1'b1, (idx < 6), 1'b0, (idx < 6) ? rows[idx] : '0, '0, '0, 1'b1);
      exp_ready = ((tb_count + tb_inflight) < RESP_DEPTH);
      checkOutput("st_req_ready", req_ready, exp_ready);
      checkOutput("st_resp_valid", resp_valid, (tb_count != 0));
      popped = 1'b0;
      if (tb_count != 0) begin
        checkOutput("st_rdata_order", resp_rdata, exp_q[0]);
        void'(exp_q.pop_front());
        popped = 1'b1;
      end
      fire_m = (idx < 6) && exp_ready;
      if (fire_m) begin
        exp_q.push_back(pat(16'(rows[idx])));
        idx++;
      end
      tb_count = tb_count + tb_inflight - int'(popped);
      tb_inflight = int'(fire_m);
      cyc++;
    end
    checkOutput("st_drained", ((idx == 6) && (exp_q.size() == 0)), 1);

    // Reset arrives the cycle after a read fires, so that read is discarded.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0001, '0, '0, 1'b1);
    checkOutput("rr_fire_ready", req_ready, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("rr_rst_ready", req_ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("rr_rst_resp_valid", resp_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checkOutput("rr_rel_ready", req_ready, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      checkOutput("rr_no_resp", resp_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
